// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access controller: issues one load/store per instruction over a
// req/ack handshake, stalls the pipeline while outstanding, flags misalignment and timeouts.
module mem_access_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_store_option,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic [31:0] me_dout,
  output logic        stall,
  output logic        misalign_exc,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               req_q;
  logic               we_q;
  logic [31:0]        addr_q;
  logic [3:0]         be_q;
  logic [31:0]        wdata_q;
  logic [31:0]        dout_q;
  logic               berr_q;

  logic               access;
  logic               is_word;
  logic               is_half;
  logic               misaligned;
  logic               start;
  logic [3:0]         be_d;
  logic [31:0]        wdata_d;

  // Reserved size code 3 behaves as a word access.
  assign access     = ex_mem_read | ex_mem_write;
  assign is_word    = (ex_store_option == 2'd0) | (ex_store_option == 2'd3);
  assign is_half    = (ex_store_option == 2'd1);
  assign misaligned = (is_word & (ex_addr[1:0] != 2'b00)) | (is_half & ex_addr[0]);
  assign start      = ex_valid & access & ~misaligned;

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = ex_wdata;
    if (is_half) begin
      wdata_d = {2{ex_wdata[15:0]}};
      if (ex_mem_write) be_d = ex_addr[1] ? 4'b1100 : 4'b0011;
    end else if (!is_word) begin
      wdata_d = {4{ex_wdata[7:0]}};
      if (ex_mem_write) be_d = 4'b0001 << ex_addr[1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      berr_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          berr_q <= 1'b0;
          if (start) begin
            req_q   <= 1'b1;
            we_q    <= ex_mem_write;
            addr_q  <= {ex_addr[31:2], 2'b00};
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt_q   <= '0;
            state_q <= REQ;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 1'b1;
          // An ack arriving on the final counted cycle still completes normally.
          if (dm_ack) begin
            req_q   <= 1'b0;
            dout_q  <= we_q ? 32'd0 : dm_rdata;
            state_q <= DONE;
          end else if (cnt_q == LAST_CNT) begin
            req_q   <= 1'b0;
            dout_q  <= 32'd0;
            berr_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          // The finished instruction is still in EX/MEM this cycle, so no new start.
          berr_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall        = ((state_q == IDLE) & start) | (state_q == REQ);
  assign misalign_exc = (state_q == IDLE) & ex_valid & access & misaligned;
  assign dm_req       = req_q;
  assign dm_we        = we_q;
  assign dm_addr      = addr_q;
  assign dm_be        = be_q;
  assign dm_wdata     = wdata_q;
  assign me_dout      = dout_q;
  assign bus_err      = berr_q;

endmodule
